a1335_i2c_responder: RTL
========================

A1335_I2C_RESPONDER -- requirements
Module: a1335_i2c_responder

Interface
REQ-001 Parameter FILTER_LEN, default 3: number of consecutive equal clock samples required before a change on synchronized SCL or SDA is accepted.
REQ-002 Parameter FLAGS, default 4'h0: constant placed in bits [7:4] of register 0x20.
REQ-003 clock  input  1  system clock; all logic is on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 scl  input  1  I2C clock from the bus master.
REQ-006 sda  inout  1  I2C data; driven only as 0 or Z (open drain).
REQ-007 device_id  input  7  bus address this responder answers to.
REQ-008 angle  input  12  live angle value to be served.
REQ-009 status  input  32  live status word to be served.
REQ-010 reg_ptr  output  8  current register pointer.
REQ-011 busy  output  1  high from an address match until the next STOP or START.
REQ-012 rd_done  output  1  one-cycle pulse when the master NACKs a read byte.
REQ-013 ack_error  output  1  high after the master ACKs the last mapped register byte (0x25); cleared at the next START.

Function
REQ-014 SCL and SDA SHALL pass through a 2-FF synchronizer, then the FILTER_LEN glitch filter; all protocol decisions use the filtered values.
REQ-015 START (filtered SDA 1->0 while SCL=1) SHALL force state ADDR with the bit counter at 0, from any state.
REQ-016 STOP (filtered SDA 0->1 while SCL=1) SHALL force state IDLE, release SDA and clear busy, from any state.
REQ-017 Data bits SHALL be sampled on filtered SCL rising, MSB first.
REQ-018 Driven SDA values SHALL change only on the first cycle after filtered SCL falling.
REQ-019 States SHALL be IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK.
REQ-020 ADDR: after 8 bits, if bits[7:1] equal device_id, go to ADDR_ACK and set busy; otherwise go to IDLE and ignore the bus until the next START.
REQ-021 ADDR_ACK: drive SDA low for one SCL period.
REQ-022 ADDR_ACK exit, R/W=0: go to PTR.
REQ-023 ADDR_ACK exit, R/W=1: go to RDATA, with angle and status captured into a snapshot on the address-match cycle.
REQ-024 PTR: after 8 bits, load reg_ptr and ACK (PTR_ACK), then go to WDATA.
REQ-025 WDATA: each byte SHALL be ACKed and discarded, and reg_ptr incremented (WDATA_ACK).
REQ-026 Register map (read-only, from the snapshot): 0x20={FLAGS,angle[11:8]}, 0x21=angle[7:0], 0x22..0x25=status[31:24]..status[7:0], all other addresses read 8'h00.
REQ-027 RDATA: shift out the byte at reg_ptr, driving SDA low for 0-bits and Z for 1-bits, then release SDA for RD_MACK.
REQ-028 RD_MACK, master ACK (SDA=0): increment reg_ptr and return to RDATA.
REQ-029 RD_MACK, master NACK: increment reg_ptr, pulse rd_done and go to IDLE (busy stays high until STOP or START).
REQ-030 reg_ptr SHALL wrap 8'hFF->8'h00, and SHALL retain its value across transactions, so a read without a pointer write continues from the last value.
REQ-031 A repeated START SHALL preserve reg_ptr; a read after a repeated START SHALL take a fresh snapshot.
REQ-032 START and SCL edge detected in the same cycle: START takes priority.

Reset
REQ-033 While reset=1, sda SHALL be Z and the state IDLE.
REQ-034 Reset values: reg_ptr=0, busy=0, rd_done=0, ack_error=0, snapshot=0, filters=1.
REQ-035 Reset asserted mid-transfer SHALL release SDA on the next clock edge and ignore the bus until a new START.

Verification
REQ-036 device_id=0x0C, angle=12'hABC, FLAGS=0: write 0x18,0x20 / Sr / 0x19, read 3 bytes ACK,ACK,NACK -> bytes 0x0A,0xBC,0x12 with status=32'h12345678; rd_done pulses once; reg_ptr=0x23.
REQ-037 Address 0x0D with device_id=0x0C -> SDA never driven low; busy stays 0.
REQ-038 angle changes 12'hABC->12'h123 mid-read of byte 0x20 -> returned bytes 0x0A,0xBC (snapshot is coherent).
REQ-039 Pointer 0xFF, read 2 bytes -> 0x00,0x00; reg_ptr=0x01.
REQ-040 One-clock SDA glitch while SCL high with FILTER_LEN=3 -> no START or STOP is detected.
REQ-041 Reset pulse during RDATA while driving 0 -> sda=Z next cycle; a following full transaction completes correctly.

Source files
------------

// File: rtl/a1335_i2c_responder.sv
// I2C target that serves a latched angle/status register map.
// Glitch-filtered SCL/SDA, open-drain SDA, auto-incrementing reg_ptr.
//
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   scl, sda     : I2C bus (sda driven only as 0 or Z)
//   device_id    : 7-bit bus address this responder answers to
//   angle,status : live values, snapshotted at a read address match
//   reg_ptr      : current register pointer
//   busy         : address matched, until the next STOP or START
//   rd_done      : one-cycle pulse when the master NACKs a read byte
//   ack_error    : master ACKed byte 0x25; cleared at the next START
module a1335_i2c_responder #(
  parameter int         FILTER_LEN = 3,
  parameter logic [3:0] FLAGS      = 4'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        scl,
  inout  wire         sda,
  input  logic [6:0]  device_id,
  input  logic [11:0] angle,
  input  logic [31:0] status,
  output logic [7:0]  reg_ptr,
  output logic        busy,
  output logic        rd_done,
  output logic        ack_error
);

  localparam int CW =
    (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CMAX = CW'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RD_MACK
  } state_t;

  state_t      state;
  logic [1:0]  scl_s, sda_s;
  logic        scl_f, sda_f;
  logic        scl_d, sda_d;
  logic [CW-1:0] scl_c, sda_c;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        rw;
  logic        ack_drv;
  logic        got_ack;
  logic        sda_oe;
  logic [11:0] snap_angle;
  logic [31:0] snap_status;
  logic [7:0]  cur_byte;

  logic scl_rise, scl_fall;
  logic start_c, stop_c;

  // Reset gates the driver directly so SDA is released
  // for the whole time reset is held.
  assign sda = (sda_oe && !reset) ? 1'b0 : 1'bz;

  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign start_c  = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_c   = scl_f & scl_d & ~sda_d & sda_f;

  // Synchronizer and glitch filter: a new level is accepted
  // only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
      scl_c <= '0;
      sda_c <= '0;
    end else begin
      scl_s <= {scl_s[0], scl};
      sda_s <= {sda_s[0], sda};
      scl_d <= scl_f;
      sda_d <= sda_f;
      if (scl_s[1] == scl_f) begin
        scl_c <= '0;
      end else if (scl_c == CMAX) begin
        scl_f <= scl_s[1];
        scl_c <= '0;
      end else begin
        scl_c <= scl_c + 1'b1;
      end
      if (sda_s[1] == sda_f) begin
        sda_c <= '0;
      end else if (sda_c == CMAX) begin
        sda_f <= sda_s[1];
        sda_c <= '0;
      end else begin
        sda_c <= sda_c + 1'b1;
      end
    end
  end

  always_comb begin
    cur_byte = 8'h00;
    case (reg_ptr)
      8'h20:   cur_byte = {FLAGS, snap_angle[11:8]};
      8'h21:   cur_byte = snap_angle[7:0];
      8'h22:   cur_byte = snap_status[31:24];
      8'h23:   cur_byte = snap_status[23:16];
      8'h24:   cur_byte = snap_status[15:8];
      8'h25:   cur_byte = snap_status[7:0];
      default: cur_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      rw          <= 1'b0;
      ack_drv     <= 1'b0;
      got_ack     <= 1'b0;
      sda_oe      <= 1'b0;
      reg_ptr     <= '0;
      busy        <= 1'b0;
      rd_done     <= 1'b0;
      ack_error   <= 1'b0;
      snap_angle  <= '0;
      snap_status <= '0;
    end else begin
      rd_done <= 1'b0;
      if (start_c) begin
        state     <= ADDR;
        bit_cnt   <= '0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        ack_error <= 1'b0;
        ack_drv   <= 1'b0;
        got_ack   <= 1'b0;
      end else if (stop_c) begin
        state   <= IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        ack_drv <= 1'b0;
        got_ack <= 1'b0;
      end else begin
        unique case (state)
          IDLE: ;
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              shreg <= {shreg[6:0], sda_f};
              if (bit_cnt != 3'd7) begin
                bit_cnt <= bit_cnt + 1'b1;
              end else begin
                bit_cnt <= '0;
                if (state == PTR) begin
                  reg_ptr <= {shreg[6:0], sda_f};
                  state   <= PTR_ACK;
                end else if (state == WDATA) begin
                  reg_ptr <= reg_ptr + 8'd1;
                  state   <= WDATA_ACK;
                end else if (shreg[6:0] == device_id) begin
                  state <= ADDR_ACK;
                  busy  <= 1'b1;
                  rw    <= sda_f;
                  if (sda_f) begin
                    snap_angle  <= angle;
                    snap_status <= status;
                  end
                end else begin
                  state <= IDLE;
                end
              end
            end
          end
          // First SCL fall starts the ACK, second one ends it.
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_drv) begin
                sda_oe  <= 1'b1;
                ack_drv <= 1'b1;
              end else begin
                ack_drv <= 1'b0;
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                if (state == ADDR_ACK && rw) begin
                  state  <= RDATA;
                  shreg  <= cur_byte;
                  sda_oe <= ~cur_byte[7];
                end else if (state == ADDR_ACK) begin
                  state <= PTR;
                end else begin
                  state <= WDATA;
                end
              end
            end
          end
          RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                got_ack <= 1'b0;
                state   <= RD_MACK;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= {shreg[6:0], 1'b0};
                sda_oe  <= ~shreg[6];
              end
            end
          end
          // ACK: wait for the SCL fall, then drive the next MSB.
          RD_MACK: begin
            if (scl_rise) begin
              reg_ptr <= reg_ptr + 8'd1;
              if (!sda_f) begin
                got_ack <= 1'b1;
                if (reg_ptr == 8'h25) ack_error <= 1'b1;
              end else begin
                rd_done <= 1'b1;
                state   <= IDLE;
              end
            end else if (scl_fall && got_ack) begin
              got_ack <= 1'b0;
              bit_cnt <= '0;
              shreg   <= cur_byte;
              sda_oe  <= ~cur_byte[7];
              state   <= RDATA;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
